// File: rtl/seg7_scan_ctrl_if.sv
// Digit-update handshake: sender offers four BCD-style codes with valid, scanner answers ready.
interface seg7_scan_ctrl_if;
  logic       upd_valid;
  logic       upd_ready;
  logic [3:0] upd_num1;
  logic [3:0] upd_num2;
  logic [3:0] upd_num3;
  logic [3:0] upd_num4;

  modport master (output upd_valid, upd_num1, upd_num2, upd_num3, upd_num4, input upd_ready);
  modport slave  (input upd_valid, upd_num1, upd_num2, upd_num3, upd_num4, output upd_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 4-digit common-anode scanner: dead-time + PWM window per slot, outputs decode registered state (0 latency).
// upd_ready stays low while a shadow set waits for the frame boundary; SEG7_LZB_EN adds leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int SLOT_CYC = 50000,
  parameter int DEAD_CYC = 1000,
  parameter int CNT_W    = 16
) (
  input  logic            i_sys_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [2:0]      i_bright,
  seg7_scan_ctrl_if.slave upd,
  output logic [3:0]      o_num_sel,
  output logic            o_D1_sel,
  output logic            o_D2_sel,
  output logic            o_D3_sel,
  output logic            o_D4_sel,
  output logic            o_blank,
  output logic            o_frame_done
);

  localparam int ON_CYC = SLOT_CYC - DEAD_CYC;
  localparam int STEP   = ON_CYC / 8;
  localparam logic [CNT_W-1:0] DEAD_V = CNT_W'(DEAD_CYC);
  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(SLOT_CYC - 1);

  if (ON_CYC <= 0 || (ON_CYC % 8) != 0 || (longint'(1) << CNT_W) <= longint'(SLOT_CYC)) begin : g_bad_cfg
    $error("seg7_scan_ctrl: illegal SLOT_CYC/DEAD_CYC/CNT_W combination");
  end

  logic [CNT_W-1:0] r_slot_cnt;
  logic [1:0]       r_idx;
  logic [2:0]       r_bright_q;
  logic [3:0]       r_act [4];
  logic [3:0]       r_shd [4];
  logic             r_pending;

  logic [CNT_W-1:0] w_on_len;
  logic [CNT_W-1:0] w_win_end;
  logic             w_frame_done;
  logic             w_xfer;
  logic             w_commit;
  logic             w_supp;
  logic             w_drive;

  assign w_on_len     = CNT_W'((int'(r_bright_q) + 1) * STEP);
  assign w_win_end    = DEAD_V + w_on_len;
  assign w_frame_done = i_en && (r_idx == 2'd3) && (r_slot_cnt == LAST_V);
  assign w_xfer       = upd.upd_valid && !r_pending;
  // With scanning stopped there is no frame to tear, so a pending set lands at once.
  assign w_commit     = r_pending && (w_frame_done || !i_en);

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      r_slot_cnt <= '0;
      r_idx      <= '0;
      r_bright_q <= '0;
      r_pending  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_act[k] <= '0;
        r_shd[k] <= '0;
      end
    end else begin
      if (!i_en) begin
        r_slot_cnt <= '0;
        r_idx      <= '0;
      end else if (r_slot_cnt == LAST_V) begin
        r_slot_cnt <= '0;
        r_idx      <= r_idx + 2'd1;
      end else begin
        r_slot_cnt <= r_slot_cnt + 1'b1;
      end

      if (r_slot_cnt == '0) begin
        r_bright_q <= i_bright;
      end

      if (w_commit) begin
        for (int k = 0; k < 4; k++) begin
          r_act[k] <= r_shd[k];
        end
        r_pending <= 1'b0;
      end else if (w_xfer) begin
        r_shd[0]  <= upd.upd_num1;
        r_shd[1]  <= upd.upd_num2;
        r_shd[2]  <= upd.upd_num3;
        r_shd[3]  <= upd.upd_num4;
        r_pending <= 1'b1;
      end
    end
  end

`ifdef SEG7_LZB_EN
  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    w_supp = 1'b0;
    case (r_idx)
      2'd0:    w_supp = (r_act[0] == 4'd0);
      2'd1:    w_supp = (r_act[0] == 4'd0) && (r_act[1] == 4'd0);
      2'd2:    w_supp = (r_act[0] == 4'd0) && (r_act[1] == 4'd0) && (r_act[2] == 4'd0);
      default: w_supp = 1'b0;
    endcase
  end
`else
  assign w_supp = 1'b0;
`endif

  assign w_drive = i_en && (r_slot_cnt >= DEAD_V) && (r_slot_cnt < w_win_end) && !w_supp;

  assign o_D1_sel      = ~(w_drive && (r_idx == 2'd0));
  assign o_D2_sel      = ~(w_drive && (r_idx == 2'd1));
  assign o_D3_sel      = ~(w_drive && (r_idx == 2'd2));
  assign o_D4_sel      = ~(w_drive && (r_idx == 2'd3));
  assign o_blank       = ~w_drive;
  assign o_frame_done  = w_frame_done;
  assign o_num_sel     = r_act[r_idx];
  assign upd.upd_ready = ~r_pending;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: frame-position reference model plus directed and randomized scenarios.
module tb_seg7_scan_ctrl;
  localparam int SLOT  = 20;
  localparam int DEAD  = 4;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] bright;
  logic [3:0] num_sel;
  logic       d1, d2, d3, d4, blank, fd;

  int n_chk  = 0;
  int n_fail = 0;

  seg7_scan_ctrl_if u_if ();

  seg7_scan_ctrl #(.SLOT_CYC(SLOT), .DEAD_CYC(DEAD), .CNT_W(5)) dut (
    .i_sys_clk   (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_bright    (bright),
    .upd         (u_if),
    .o_num_sel   (num_sel),
    .o_D1_sel    (d1),
    .o_D2_sel    (d2),
    .o_D3_sel    (d3),
    .o_D4_sel    (d4),
    .o_blank     (blank),
    .o_frame_done(fd)
  );

  always #5 clk = ~clk;

  // Reference: position within the frame, captured brightness, digit sets.
  int m_pos;
  int m_bq;
  int m_act [4];
  int m_shd [4];
  bit m_pend;

  always @(posedge clk) begin
    if (rst) begin
      m_pos  <= 0;
      m_bq   <= 0;
      m_pend <= 1'b0;
      m_act  <= '{default: 0};
      m_shd  <= '{default: 0};
    end else begin
      if (m_pos % SLOT == 0) m_bq <= int'(bright);
      if (m_pend && (!en || m_pos == FRAME - 1)) begin
        m_act  <= m_shd;
        m_pend <= 1'b0;
      end else if (u_if.upd_valid && !m_pend) begin
        m_shd  <= '{int'(u_if.upd_num1), int'(u_if.upd_num2), int'(u_if.upd_num3), int'(u_if.upd_num4)};
        m_pend <= 1'b1;
      end
      m_pos <= en ? (m_pos + 1) % FRAME : 0;
    end
  end

  function automatic bit lzb_supp(int slot);
`ifdef SEG7_LZB_EN
    int sum = 0;
    for (int k = 0; k <= slot; k++) sum += m_act[k];
    return (slot < 3) && (sum == 0);
`else
    return slot > 3;
`endif
  endfunction

  function automatic logic [10:0] exp_vec();
    int slot, c, on_len;
    logic drv;
    logic [3:0] sel;
    slot   = m_pos / SLOT;
    c      = m_pos % SLOT;
    on_len = (m_bq + 1) * ((SLOT - DEAD) / 8);
    drv    = en && (c >= DEAD) && (c < DEAD + on_len) && !lzb_supp(slot);
    sel    = 4'b1111;
    if (drv) sel[3 - slot] = 1'b0;
    return {sel, ~drv, en && (m_pos == FRAME - 1), ~m_pend, 4'(m_act[slot])};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {d1, d2, d3, d4, blank, fd, u_if.upd_ready, num_sel};
  endfunction

  task automatic set_nums(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    u_if.upd_num1 = a;
    u_if.upd_num2 = b;
    u_if.upd_num3 = c;
    u_if.upd_num4 = d;
  endtask

  task automatic wait_pos(input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (m_pos == p) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; bright = 3'd7; u_if.upd_valid = 1'b0;
    set_nums(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (2) @(negedge clk);
    n_chk++; if ({d1, d2, d3, d4} !== 4'hF) begin n_fail++; $display("FAIL reset_sel got=%b exp=1111", {d1, d2, d3, d4}); end
    n_chk++; if (blank !== 1'b1) begin n_fail++; $display("FAIL reset_blank got=%b exp=1", blank); end
    n_chk++; if (u_if.upd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", u_if.upd_ready); end
    n_chk++; if ({fd, num_sel} !== 5'd0) begin n_fail++; $display("FAIL reset_fd_num got=%b exp=00000", {fd, num_sel}); end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    int fd_cnt = 0, fd_first = -1, fd_last = -1, drv_cnt = 0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      @(negedge clk);
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL scan pos=%0d got=%h exp=%h", m_pos, dut_vec(), exp_vec()); end
      if (fd === 1'b1) begin
        fd_cnt++;
        if (fd_first < 0) fd_first = i;
        fd_last = i;
      end
      if (blank === 1'b0) drv_cnt++;
    end
    n_chk++; if (fd_cnt != 2 || fd_last - fd_first != FRAME) begin n_fail++; $display("FAIL scan_frame_done got=%0d pulses gap %0d exp=2 pulses gap 80", fd_cnt, fd_last - fd_first); end
    n_chk++; if (drv_cnt != 128) begin n_fail++; $display("FAIL scan_drive_cycles got=%0d exp=128", drv_cnt); end
  endtask

  task automatic test_brightness();
    bit ok;
    int cnt [2], first [2], last [2];
    cnt = '{0, 0}; first = '{-1, -1}; last = '{-1, -1};
    bright = 3'd0;
    @(negedge clk);
    for (int i = 0; i < 4 * FRAME && (m_pos % SLOT) != 1; i++) @(negedge clk);
    ok = (m_pos % SLOT) == 1;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bright_wait got pos=%0d exp slot offset 1", m_pos); end
    for (int j = 0; j < 39; j++) begin
      int s, c;
      s = (j < 19) ? 0 : 1;
      c = m_pos % SLOT;
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL bright pos=%0d got=%h exp=%h", m_pos, dut_vec(), exp_vec()); end
      if (blank === 1'b0) begin
        cnt[s]++;
        if (first[s] < 0) first[s] = c;
        last[s] = c;
      end
      if (j == 9) bright = 3'd3;
      @(negedge clk);
    end
    n_chk++; if (cnt[0] != 2 || first[0] != 4 || last[0] != 5) begin n_fail++; $display("FAIL bright0_window got=%0d cyc %0d..%0d exp=2 cyc 4..5", cnt[0], first[0], last[0]); end
    n_chk++; if (cnt[1] != 8 || first[1] != 4 || last[1] != 11) begin n_fail++; $display("FAIL bright3_window got=%0d cyc %0d..%0d exp=8 cyc 4..11", cnt[1], first[1], last[1]); end
    bright = 3'd7;
  endtask

  task automatic test_update();
    bit ok;
    wait_pos(30, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL upd_wait got pos=%0d exp=30", m_pos); end
    u_if.upd_valid = 1'b1; set_nums(4'd1, 4'd2, 4'd3, 4'd4);
    @(negedge clk);
    n_chk++; if (u_if.upd_ready !== 1'b0) begin n_fail++; $display("FAIL upd_ready_drop got=%b exp=0", u_if.upd_ready); end
    u_if.upd_valid = 1'b0;
    for (int i = 0; i < FRAME && m_pos != 0; i++) begin
      n_chk++; if (num_sel !== 4'd0 || u_if.upd_ready !== 1'b0) begin n_fail++; $display("FAIL upd_hold pos=%0d got num=%0d rdy=%b exp num=0 rdy=0", m_pos, num_sel, u_if.upd_ready); end
      @(negedge clk);
    end
    n_chk++; if (u_if.upd_ready !== 1'b1) begin n_fail++; $display("FAIL upd_ready_back got=%b exp=1", u_if.upd_ready); end
    for (int i = 0; i < FRAME; i++) begin
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL upd pos=%0d got=%h exp=%h", m_pos, dut_vec(), exp_vec()); end
      if (m_pos % SLOT == 10) begin
        n_chk++; if (num_sel !== 4'(m_pos / SLOT + 1)) begin n_fail++; $display("FAIL upd_num slot=%0d got=%0d exp=%0d", m_pos / SLOT, num_sel, m_pos / SLOT + 1); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int acc_pos = -1;
    logic [3:0] a [4];
    logic [3:0] b [4];
    for (int k = 0; k < 4; k++) begin
      a[k] = 4'($urandom_range(0, 15));
      b[k] = a[k] + 4'($urandom_range(1, 15));
    end
    wait_pos(20, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_wait got pos=%0d exp=20", m_pos); end
    u_if.upd_valid = 1'b1; set_nums(a[0], a[1], a[2], a[3]);
    @(negedge clk);
    n_chk++; if (u_if.upd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_first got=%b exp=0", u_if.upd_ready); end
    set_nums(b[0], b[1], b[2], b[3]);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL bp pos=%0d got=%h exp=%h", m_pos, dut_vec(), exp_vec()); end
      if (u_if.upd_ready === 1'b1) begin
        acc_pos = m_pos;
        break;
      end
    end
    n_chk++; if (acc_pos != 0) begin n_fail++; $display("FAIL bp_accept_pos got=%0d exp=0", acc_pos); end
    @(negedge clk);
    u_if.upd_valid = 1'b0;
    for (int i = 0; i < 2 * FRAME - 1; i++) begin
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL bp pos=%0d got=%h exp=%h", m_pos, dut_vec(), exp_vec()); end
      if (m_pos % SLOT == 10) begin
        logic [3:0] want;
        want = (i < FRAME - 1) ? a[m_pos / SLOT] : b[m_pos / SLOT];
        n_chk++; if (num_sel !== want) begin n_fail++; $display("FAIL bp_num i=%0d got=%0d exp=%0d", i, num_sel, want); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_enable();
    bit ok;
    int first = -1;
    logic [3:0] first_sel = 4'hF;
    logic [3:0] c0;
    wait_pos(45, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL en_wait got pos=%0d exp=45", m_pos); end
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_chk++; if ({d1, d2, d3, d4, blank, fd} !== 6'b111110) begin n_fail++; $display("FAIL en_off got=%b exp=111110", {d1, d2, d3, d4, blank, fd}); end
    end
    c0 = 4'($urandom_range(1, 15));
    u_if.upd_valid = 1'b1; set_nums(c0, 4'($urandom), 4'($urandom), 4'($urandom));
    @(negedge clk);
    n_chk++; if (u_if.upd_ready !== 1'b0) begin n_fail++; $display("FAIL en_off_xfer got=%b exp=0", u_if.upd_ready); end
    u_if.upd_valid = 1'b0;
    @(negedge clk);
    n_chk++; if ({u_if.upd_ready, num_sel} !== {1'b1, c0}) begin n_fail++; $display("FAIL en_off_commit got=%b exp=%b", {u_if.upd_ready, num_sel}, {1'b1, c0}); end
    en = 1'b1;
    for (int j = 1; j <= SLOT; j++) begin
      @(negedge clk);
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL en_on pos=%0d got=%h exp=%h", m_pos, dut_vec(), exp_vec()); end
      if (first < 0 && {d1, d2, d3, d4} !== 4'hF) begin
        first = j;
        first_sel = {d1, d2, d3, d4};
      end
    end
    n_chk++; if (first != DEAD || first_sel !== 4'b0111) begin n_fail++; $display("FAIL en_restart got=cyc %0d sel %b exp=cyc 4 sel 0111", first, first_sel); end
  endtask

  task automatic test_reset_pending();
    bit ok;
    wait_pos(50, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rstp_wait got pos=%0d exp=50", m_pos); end
    u_if.upd_valid = 1'b1;
    set_nums(4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)));
    @(negedge clk);
    n_chk++; if (u_if.upd_ready !== 1'b0) begin n_fail++; $display("FAIL rstp_xfer got=%b exp=0", u_if.upd_ready); end
    u_if.upd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      n_chk++; if ({u_if.upd_ready, num_sel} !== 5'b10000) begin n_fail++; $display("FAIL rstp_drop pos=%0d got=%b exp=10000", m_pos, {u_if.upd_ready, num_sel}); end
      @(negedge clk);
    end
  endtask

`ifdef SEG7_LZB_EN
  task automatic test_lzb();
    logic [3:0] pat [2][4];
    int exp_cnt [2][4];
    int cnt [4];
    pat     = '{'{4'd0, 4'd0, 4'd5, 4'd0}, '{4'd0, 4'd0, 4'd0, 4'd0}};
    exp_cnt = '{'{0, 0, 16, 16}, '{0, 0, 0, 16}};
    bright = 3'd7;
    for (int p = 0; p < 2; p++) begin
      en = 1'b0;
      u_if.upd_valid = 1'b1; set_nums(pat[p][0], pat[p][1], pat[p][2], pat[p][3]);
      @(negedge clk);
      u_if.upd_valid = 1'b0;
      @(negedge clk);
      en = 1'b1;
      cnt = '{0, 0, 0, 0};
      for (int i = 0; i < FRAME; i++) begin
        @(negedge clk);
        n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL lzb pos=%0d got=%h exp=%h", m_pos, dut_vec(), exp_vec()); end
        if (d1 === 1'b0) cnt[0]++;
        if (d2 === 1'b0) cnt[1]++;
        if (d3 === 1'b0) cnt[2]++;
        if (d4 === 1'b0) cnt[3]++;
      end
      for (int k = 0; k < 4; k++) begin
        n_chk++; if (cnt[k] != exp_cnt[p][k]) begin n_fail++; $display("FAIL lzb_cnt pat=%0d digit=%0d got=%0d exp=%0d", p, k + 1, cnt[k], exp_cnt[p][k]); end
      end
    end
  endtask
`endif

  task automatic test_random();
    bit fl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n_chk++; if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL rand i=%0d pos=%0d got=%h exp=%h", i, m_pos, dut_vec(), exp_vec()); end
      if (fl) u_if.upd_valid = 1'b0;
      if (!u_if.upd_valid && $urandom_range(0, 5) == 0) begin
        u_if.upd_valid = 1'b1;
        set_nums(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      end
      fl = u_if.upd_valid && u_if.upd_ready;
      if ($urandom_range(0, 24) == 0) bright = 3'($urandom);
      if ($urandom_range(0, 149) == 0) en = ~en;
    end
    en = 1'b1;
    u_if.upd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_brightness();
    test_update();
    test_back_to_back();
    test_enable();
    test_reset_pending();
`ifdef SEG7_LZB_EN
    test_lzb();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
